// File: rtl/lr_col_pack.sv
// lr_col_pack: joins a left and a right pixel stream into one LR stream.
// Each L/R word pair is decimated 2:1 horizontally and interleaved into one
// output word {aR, aL, bR, bL}. The block does not emit until both inputs
// reach a frame start together. Any sideband disagreement drops the pair
// and returns the block to frame search. The output goes through a
// two-entry skid buffer. Its registered full flag is what breaks the path
// from m_axis_lr_tready back to the input readies.
module lr_col_pack #(
    parameter int C_AXIS_LR_TDATA_WIDTH = 32,
    parameter int AVG_MODE              = 0
) (
    input  logic                             aclk,
    input  logic                             aresetn,

    input  logic [C_AXIS_LR_TDATA_WIDTH-1:0] s_axis_l_tdata,
    input  logic                             s_axis_l_tvalid,
    output logic                             s_axis_l_tready,
    input  logic                             s_axis_l_tlast,
    input  logic                             s_axis_l_tuser,

    input  logic [C_AXIS_LR_TDATA_WIDTH-1:0] s_axis_r_tdata,
    input  logic                             s_axis_r_tvalid,
    output logic                             s_axis_r_tready,
    input  logic                             s_axis_r_tlast,
    input  logic                             s_axis_r_tuser,

    output logic [C_AXIS_LR_TDATA_WIDTH-1:0] m_axis_lr_tdata,
    output logic                             m_axis_lr_tvalid,
    input  logic                             m_axis_lr_tready,
    output logic                             m_axis_lr_tlast,
    output logic                             m_axis_lr_tuser,

    output logic                             sync_o,
    output logic [7:0]                       err_cnt_o
);

    localparam int W = C_AXIS_LR_TDATA_WIDTH;

    // SYNC searches for a common frame start; RUN joins pairs.
    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // Skid buffer: the output register is the head, and the skid register
    // is the second entry. A valid skid entry means the buffer is full.
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_user_q, out_user_d;
    logic          skid_valid_q, skid_valid_d;
    logic [W-1:0]  skid_data_q, skid_data_d;
    logic          skid_last_q, skid_last_d;
    logic          skid_user_q, skid_user_d;

    logic          full;
    logic          pair_valid;
    logic          side_mismatch;
    logic          push;
    logic          pop;
    logic          err_inc;
    logic          l_ready;
    logic          r_ready;
    logic [W-1:0]  packed_word;

    // Index 0 is the left side and index 1 is the right side.
    logic [W-1:0]  side_word [2];
    logic [7:0]    side_a    [2];
    logic [7:0]    side_b    [2];

    assign side_word[0] = s_axis_l_tdata;
    assign side_word[1] = s_axis_r_tdata;

    // Per-side 2:1 horizontal decimation.
    // Pixel p0 sits in bits 31:24 and p3 in bits 7:0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            if (AVG_MODE == 1) begin : g_avg
                logic [8:0] sum_a;
                logic [8:0] sum_b;
                // The 9-bit sums keep the carry. The shift truncates, so no rounding is applied.
                assign sum_a      = {1'b0, side_word[gi][31:24]} + {1'b0, side_word[gi][23:16]};
                assign sum_b      = {1'b0, side_word[gi][15:8]}  + {1'b0, side_word[gi][7:0]};
                assign side_a[gi] = sum_a[8:1];
                assign side_b[gi] = sum_b[8:1];
            end else begin : g_keep
                // Odd pixels are dropped in this mode.
                logic unused_odd;
                assign unused_odd = ^{side_word[gi][23:16], side_word[gi][7:0]};
                assign side_a[gi] = side_word[gi][31:24];
                assign side_b[gi] = side_word[gi][15:8];
            end
        end
    endgenerate

    // Interleave the decimated pixels, with right before left in each half.
    assign packed_word = {side_a[1], side_a[0], side_b[1], side_b[0]};

    assign full          = skid_valid_q;
    assign pair_valid    = s_axis_l_tvalid & s_axis_r_tvalid;
    assign side_mismatch = (s_axis_l_tuser ^ s_axis_r_tuser) | (s_axis_l_tlast ^ s_axis_r_tlast);
    assign pop           = out_valid_q & m_axis_lr_tready;

    // State register and error counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_SYNC;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next state, input readies, and the push/error decisions.
    always_comb begin
        state_d = state_q;
        l_ready = 1'b0;
        r_ready = 1'b0;
        push    = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            ST_SYNC: begin
                // Heads that are not a frame start are dropped. A frame-start head waits for the other side.
                l_ready = s_axis_l_tvalid & ~s_axis_l_tuser;
                r_ready = s_axis_r_tvalid & ~s_axis_r_tuser;
                if (s_axis_l_tvalid & s_axis_l_tuser & s_axis_r_tvalid & s_axis_r_tuser) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pair_valid & side_mismatch) begin
                    // A broken pair is dropped even when the buffer is full.
                    l_ready = 1'b1;
                    r_ready = 1'b1;
                    err_inc = 1'b1;
                    state_d = ST_SYNC;
                end else begin
                    l_ready = s_axis_r_tvalid & ~full;
                    r_ready = s_axis_l_tvalid & ~full;
                    push    = pair_valid & ~full;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Saturating count of dropped (mismatched) pairs.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Skid buffer next state. Words leave in the order they entered.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_user_d   = out_user_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_user_d  = skid_user_q;
        if (skid_valid_q) begin
            // The buffer is full, so push is blocked. Only draining is possible.
            if (pop) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                out_user_d   = skid_user_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || pop) begin
                out_valid_d = 1'b1;
                out_data_d  = packed_word;
                out_last_d  = s_axis_l_tlast;
                out_user_d  = s_axis_l_tuser;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = packed_word;
                skid_last_d  = s_axis_l_tlast;
                skid_user_d  = s_axis_l_tuser;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Skid buffer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_user_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_user_q   <= out_user_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_user_q  <= skid_user_d;
        end
    end

    assign s_axis_l_tready  = l_ready;
    assign s_axis_r_tready  = r_ready;
    assign m_axis_lr_tvalid = out_valid_q;
    assign m_axis_lr_tdata  = out_data_q;
    assign m_axis_lr_tlast  = out_last_q;
    assign m_axis_lr_tuser  = out_user_q;
    assign sync_o           = (state_q == ST_RUN);
    assign err_cnt_o        = err_cnt_q;

endmodule
